axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read master port between NUM_REQ memcopy read engines (axi_master_rd instances) in the multi-process action.
- Arbitrates AR bursts round-robin and prefixes each ARID with the requester index.
- Limits outstanding bursts per requester.
- Routes R beats back to the owning engine by the RID prefix.

Parameters:
- NUM_REQ, 4, number of requesting engines (power of 2, 2..8)
- SEL_WIDTH, 2, log2(NUM_REQ); width of the ID prefix
- ID_WIDTH, 2, engine-side AXI ID width
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 512, AXI data width
- ARUSER_WIDTH, 8, ARUSER width
- MAX_OUTSTANDING, 16, maximum bursts in flight per requester (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_axi_arid  in  NUM_REQ*ID_WIDTH  per-requester ARID, requester i in slice i
- s_axi_araddr  in  NUM_REQ*ADDR_WIDTH  per-requester ARADDR
- s_axi_arlen  in  NUM_REQ*8  per-requester ARLEN
- s_axi_arsize  in  NUM_REQ*3  per-requester ARSIZE
- s_axi_aruser  in  NUM_REQ*ARUSER_WIDTH  per-requester ARUSER
- s_axi_arvalid  in  NUM_REQ  per-requester ARVALID
- s_axi_arready  out  NUM_REQ  per-requester ARREADY
- s_axi_rid  out  ID_WIDTH  RID with prefix stripped; broadcast to all requesters
- s_axi_rdata  out  DATA_WIDTH  broadcast RDATA
- s_axi_rresp  out  2  broadcast RRESP
- s_axi_rlast  out  1  broadcast RLAST
- s_axi_rvalid  out  NUM_REQ  per-requester RVALID
- s_axi_rready  in  NUM_REQ  per-requester RREADY
- m_axi_arid  out  SEL_WIDTH+ID_WIDTH  {requester index, engine ARID}
- m_axi_araddr  out  ADDR_WIDTH  master ARADDR
- m_axi_arlen  out  8  master ARLEN
- m_axi_arsize  out  3  master ARSIZE
- m_axi_arburst  out  2  constant 2'd1 (INCR)
- m_axi_aruser  out  ARUSER_WIDTH  master ARUSER
- m_axi_arvalid  out  1  master ARVALID
- m_axi_arready  in  1  master ARREADY
- m_axi_rid  in  SEL_WIDTH+ID_WIDTH  master RID
- m_axi_rdata  in  DATA_WIDTH  master RDATA
- m_axi_rresp  in  2  master RRESP
- m_axi_rlast  in  1  master RLAST
- m_axi_rvalid  in  1  master RVALID
- m_axi_rready  out  1  master RREADY
- outstanding_busy  out  1  high while any requester has bursts in flight
- err_unexpected_rlast  out  1  sticky error flag

Behaviour:
- Reset (sync, rst=1): state=IDLE; m_axi_arvalid=0; all m_axi_ar* payload registers 0; s_axi_arready=0; rr pointer=NUM_REQ-1; all outstanding counters 0; err_unexpected_rlast=0.
- Reset mid-burst drops m_axi_arvalid on the next edge; the system resets the AXI slave together with this block.
- AR state machine has two states.
- IDLE:
  - Eligible requester i: s_axi_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
  - Grant the first eligible index searching from (ptr+1) mod NUM_REQ upward with wrap.
  - On grant, combinationally assert s_axi_arready[grant] for that cycle only; this is the requester handshake.
  - Register payload: m_axi_arid = {grant[SEL_WIDTH-1:0], arid}, plus addr/len/size/user.
  - On grant, ptr<=grant, cnt[grant]+=1, go to HOLD.
  - No eligible requester: stay in IDLE.
- HOLD:
  - m_axi_arvalid=1; payload held stable; all s_axi_arready=0.
  - On m_axi_arready=1, clear arvalid and return to IDLE.
  - Minimum AR spacing is 2 cycles (1 bubble).
- Latency: requester handshake to m_axi_arvalid high is 1 cycle.
- R routing is combinational; R beats pass through with no buffering:
  - sel = m_axi_rid[top SEL_WIDTH bits].
  - s_axi_rvalid[i] = m_axi_rvalid && (sel==i).
  - m_axi_rready = s_axi_rready[sel].
  - s_axi_rid = m_axi_rid[ID_WIDTH-1:0].
  - rdata/rresp/rlast are broadcast unchanged.
- Outstanding counters (8-bit each):
  - Decrement cnt[sel] on m_axi_rvalid && m_axi_rready && m_axi_rlast.
  - Grant and rlast completion on the same requester in the same cycle: net 0 change.
  - Counter saturates at 0. An rlast completion with cnt[sel]==0 sets err_unexpected_rlast; it is cleared only by reset.
- outstanding_busy = OR over (cnt[i]!=0) OR m_axi_arvalid.
- Fairness: a requester that keeps arvalid asserted is granted at most once per NUM_REQ grants while others are eligible.
- A requester at MAX_OUTSTANDING is skipped, not stalled on; arbitration proceeds to the others.
- RRESP is not interpreted; engines check it.

Test Plan:
- Single requester 2 issues one burst (arid=1, addr=0x1000, len=7); slave returns 8 beats with rid=0b1001 → m_axi_arid=0b1001; s_axi_rvalid=0b0100 for 8 beats; s_axi_rid=1; outstanding_busy returns to 0 after rlast.
- All 4 requesters hold arvalid continuously, arready=1 → grant order 0,1,2,3,0,1…; one AR every 2 cycles; each s_axi_arready pulse lasts exactly 1 cycle.
- MAX_OUTSTANDING=2; requester 0 issues 3 bursts with no R returned → third burst not granted; requester 1 still granted; after one rlast to requester 0, its third burst is granted.
- Slave holds arready=0 for 5 cycles → m_axi_ar* stable, no s_axi_arready asserted, state stays HOLD.
- Grant to requester 3 and rlast completion for requester 3 in the same cycle with cnt[3]=1 → cnt[3] stays 1. Then inject rlast for requester 1 with cnt[1]=0 → err_unexpected_rlast=1 and stays set.
- Assert rst for 1 cycle during HOLD with 3 bursts outstanding → next cycle m_axi_arvalid=0, all counters 0, outstanding_busy=0, arbitration restarts at requester 0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Round-robin AXI4 read arbiter; ID-prefix routing of R beats and
//            per-requester outstanding-burst limiting.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int SEL_WIDTH       = 2,
    parameter int ID_WIDTH        = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ARUSER_WIDTH    = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*ID_WIDTH-1:0]       s_axi_arid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [NUM_REQ*8-1:0]              s_axi_arlen,
    input  logic [NUM_REQ*3-1:0]              s_axi_arsize,
    input  logic [NUM_REQ*ARUSER_WIDTH-1:0]   s_axi_aruser,
    input  logic [NUM_REQ-1:0]                s_axi_arvalid,
    output logic [NUM_REQ-1:0]                s_axi_arready,
    output logic [ID_WIDTH-1:0]               s_axi_rid,
    output logic [DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic [NUM_REQ-1:0]                s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                s_axi_rready,
    output logic [SEL_WIDTH+ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    output logic [ARUSER_WIDTH-1:0]           m_axi_aruser,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [SEL_WIDTH+ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic                              outstanding_busy,
    output logic                              err_unexpected_rlast
);

    localparam logic [0:0] c_idle    = 1'b0;
    localparam logic [0:0] c_hold    = 1'b1;
    localparam logic [7:0] c_max_out = 8'(MAX_OUTSTANDING);

    logic [0:0]                        r_state;
    logic [0:0]                        w_state_nxt;
    logic [SEL_WIDTH-1:0]              r_ptr;
    logic                              r_arvalid;
    logic [SEL_WIDTH+ID_WIDTH-1:0]     r_arid;
    logic [ADDR_WIDTH-1:0]             r_araddr;
    logic [7:0]                        r_arlen;
    logic [2:0]                        r_arsize;
    logic [ARUSER_WIDTH-1:0]           r_aruser;
    logic                              r_err;

    logic [NUM_REQ-1:0]                w_elig;
    logic [NUM_REQ-1:0]                w_cnt_zero;
    logic                              w_gnt_vld;
    logic [SEL_WIDTH-1:0]              w_gnt;
    logic                              w_take;
    logic [SEL_WIDTH-1:0]              w_sel;
    logic                              w_done;

    assign w_sel  = m_axi_rid[SEL_WIDTH+ID_WIDTH-1 -: SEL_WIDTH];
    assign w_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Per-requester outstanding counter; a grant and a completion in the
    // same cycle cancel, and a completion never takes the count below zero.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [7:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc          = w_take && (w_gnt == SEL_WIDTH'(gi));
            assign w_dec          = w_done && (w_sel == SEL_WIDTH'(gi)) && (r_cnt != 8'd0);
            assign w_elig[gi]     = s_axi_arvalid[gi] && (r_cnt < c_max_out);
            assign w_cnt_zero[gi] = (r_cnt == 8'd0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= 8'd0;
                end else if (w_inc && !w_dec) begin
                    r_cnt <= r_cnt + 8'd1;
                end else if (!w_inc && w_dec) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
        end
    endgenerate

    // Search starts one past the last winner and wraps naturally in SEL_WIDTH bits.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_gnt_vld && w_elig[r_ptr + SEL_WIDTH'(k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = r_ptr + SEL_WIDTH'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_gnt_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_hold;
                end
            end
            c_hold: begin
                if (m_axi_arready) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        s_axi_arready = '0;
        if (w_take && !rst) begin
            s_axi_arready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_ptr     <= SEL_WIDTH'(NUM_REQ - 1);
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_aruser  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_arvalid <= 1'b1;
                r_ptr     <= w_gnt;
                r_arid    <= {w_gnt, s_axi_arid[w_gnt*ID_WIDTH +: ID_WIDTH]};
                r_araddr  <= s_axi_araddr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                r_arlen   <= s_axi_arlen[w_gnt*8 +: 8];
                r_arsize  <= s_axi_arsize[w_gnt*3 +: 3];
                r_aruser  <= s_axi_aruser[w_gnt*ARUSER_WIDTH +: ARUSER_WIDTH];
            end else if ((r_state == c_hold) && m_axi_arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_done && w_cnt_zero[w_sel]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = 2'd1;
    assign m_axi_aruser  = r_aruser;
    assign m_axi_arvalid = r_arvalid;

    always_comb begin
        s_axi_rvalid        = '0;
        s_axi_rvalid[w_sel] = m_axi_rvalid;
    end

    assign m_axi_rready         = s_axi_rready[w_sel];
    assign s_axi_rid            = m_axi_rid[ID_WIDTH-1:0];
    assign s_axi_rdata          = m_axi_rdata;
    assign s_axi_rresp          = m_axi_rresp;
    assign s_axi_rlast          = m_axi_rlast;
    assign outstanding_busy     = r_arvalid || !(&w_cnt_zero);
    assign err_unexpected_rlast = r_err;

endmodule
`default_nettype wire
